spi_slave_mem_ifc: RTL and testbench

Parametrised SPI slave bridging an external SPI master to two on-chip block RAMs: a transmit memory read via txMemAddr/txMemData and a receive memory written via rcMemAddr/rcMemData/rcMemWE. All SPI pins are oversampled in the SysClk domain. Word width, address width and SPI mode (CPOL/CPHA) are parameters. Adds per-frame status reporting (busy, frameDone, word count).

---
 rtl/spi_slave_mem_ifc.sv | 253 +++++++++++++++++++++++++
 tb/tb_spi_slave_mem_ifc.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_mem_ifc.sv
// SPI slave bridging an external master to a transmit RAM (read) and a receive RAM (write).
// All SPI pins are oversampled in the SysClk domain; mode and widths are parameters.
module spi_slave_mem_ifc #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned ADDR_W = 12,
  parameter logic        CPOL   = 1'b0,
  parameter logic        CPHA   = 1'b0
) (
  input  logic              SysClk,
  input  logic              Reset,
  input  logic              SPI_CLK,
  input  logic              SPI_SS,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  output logic [ADDR_W-1:0] txMemAddr,
  input  logic [WORD_W-1:0] txMemData,
  output logic [ADDR_W-1:0] rcMemAddr,
  output logic [WORD_W-1:0] rcMemData,
  output logic              rcMemWE,
  output logic              busy,
  output logic              frameDone,
  output logic [ADDR_W:0]   rcWordCount
);

  localparam int unsigned       BIT_W    = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam int unsigned       CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_ACTIVE
  } state_e;

  // Pin synchronisers and edge-detect history
  logic [1:0] ss_sync_q;
  logic [1:0] clk_sync_q;
  logic [1:0] mosi_sync_q;
  logic       ss_prev_q;
  logic       clk_prev_q;
  logic [1:0] fill_q;
  logic       armed_q;

  logic ss_fall;
  logic ss_rise;
  logic clk_rise;
  logic clk_fall;
  logic lead_ev;
  logic trail_ev;
  logic sample_ev;
  logic shift_ev;
  logic mosi_s;

  state_e            state_q, state_d;
  logic              pf_q, pf_d;
  logic [1:0]        fetch_q, fetch_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [WORD_W-1:0] rx_q, rx_d;
  logic [WORD_W-1:0] tx_shift_q, tx_shift_d;
  logic [WORD_W-1:0] tx_next_q, tx_next_d;
  logic [ADDR_W-1:0] tx_addr_q, tx_addr_d;
  logic [ADDR_W-1:0] rc_addr_q, rc_addr_d;
  logic [WORD_W-1:0] rc_data_q, rc_data_d;
  logic              rc_we_q, rc_we_d;
  logic              miso_q, miso_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // After reset, SS must be seen high before a falling edge can start a frame
  always_ff @(posedge SysClk) begin
    if (Reset) begin
      ss_sync_q   <= 2'b11;
      clk_sync_q  <= {2{CPOL}};
      mosi_sync_q <= 2'b00;
      ss_prev_q   <= 1'b1;
      clk_prev_q  <= CPOL;
      fill_q      <= 2'd0;
      armed_q     <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[0], SPI_SS};
      clk_sync_q  <= {clk_sync_q[0], SPI_CLK};
      mosi_sync_q <= {mosi_sync_q[0], SPI_MOSI};
      ss_prev_q   <= ss_sync_q[1];
      clk_prev_q  <= clk_sync_q[1];
      if (fill_q != 2'd3) begin
        fill_q <= fill_q + 2'd1;
      end
      if ((fill_q == 2'd3) && ss_sync_q[1]) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign ss_fall   = armed_q & ss_prev_q & ~ss_sync_q[1];
  assign ss_rise   = ~ss_prev_q & ss_sync_q[1];
  assign clk_rise  = ~clk_prev_q & clk_sync_q[1];
  assign clk_fall  = clk_prev_q & ~clk_sync_q[1];
  assign lead_ev   = CPOL ? clk_fall : clk_rise;
  assign trail_ev  = CPOL ? clk_rise : clk_fall;
  assign sample_ev = CPHA ? trail_ev : lead_ev;
  assign shift_ev  = CPHA ? lead_ev : trail_ev;
  assign mosi_s    = mosi_sync_q[1];

  // State and datapath registers
  always_ff @(posedge SysClk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      pf_q       <= 1'b0;
      fetch_q    <= 2'd0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      rx_q       <= '0;
      tx_shift_q <= '0;
      tx_next_q  <= '0;
      tx_addr_q  <= '0;
      rc_addr_q  <= '0;
      rc_data_q  <= '0;
      rc_we_q    <= 1'b0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pf_q       <= pf_d;
      fetch_q    <= fetch_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      rx_q       <= rx_d;
      tx_shift_q <= tx_shift_d;
      tx_next_q  <= tx_next_d;
      tx_addr_q  <= tx_addr_d;
      rc_addr_q  <= rc_addr_d;
      rc_data_q  <= rc_data_d;
      rc_we_q    <= rc_we_d;
      miso_q     <= miso_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      count_q    <= count_d;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d    = state_q;
    pf_d       = pf_q;
    fetch_d    = (fetch_q != 2'd0) ? (fetch_q - 2'd1) : 2'd0;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    rx_d       = rx_q;
    tx_shift_d = tx_shift_q;
    tx_next_d  = tx_next_q;
    tx_addr_d  = tx_addr_q;
    rc_addr_d  = rc_addr_q;
    rc_data_d  = rc_data_q;
    rc_we_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    count_d    = count_q;

    // Staging fetch: RAM output for the freshly incremented address is valid two cycles after a load
    if (fetch_q == 2'd1) begin
      tx_next_d = txMemData;
    end
    if (rc_we_q) begin
      rc_addr_d = rc_addr_q + ADDR_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d    = ST_PREFETCH;
          pf_d       = 1'b0;
          fetch_d    = 2'd0;
          tx_addr_d  = '0;
          rc_addr_d  = '0;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          busy_d     = 1'b1;
        end
      end

      ST_PREFETCH: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          count_d = word_cnt_q;
        end else if (pf_q) begin
          state_d    = ST_ACTIVE;
          tx_shift_d = txMemData;
          tx_addr_d  = tx_addr_q + ADDR_W'(1);
          fetch_d    = 2'd2;
        end else begin
          pf_d = 1'b1;
        end
      end

      ST_ACTIVE: begin
        // Word 0 is already in the shifter from prefetch, so CPHA=1 skips its load
        if (shift_ev) begin
          if (bit_cnt_q == '0) begin
            if ((CPHA == 1'b0) || (word_cnt_q != '0)) begin
              tx_shift_d = tx_next_q;
              tx_addr_d  = tx_addr_q + ADDR_W'(1);
              fetch_d    = 2'd2;
            end
          end else begin
            tx_shift_d = tx_shift_q << 1;
          end
        end
        if (sample_ev) begin
          rx_d = {rx_q[WORD_W-2:0], mosi_s};
          if (bit_cnt_q == BIT_LAST) begin
            rc_data_d = rx_d;
            rc_we_d   = 1'b1;
            bit_cnt_d = '0;
            if (word_cnt_q != CNT_MAX) begin
              word_cnt_d = word_cnt_q + CNT_W'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
        if (ss_rise) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          count_d = word_cnt_d;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    miso_d = (state_d != ST_IDLE) ? tx_shift_d[WORD_W-1] : 1'b0;
  end

  assign SPI_MISO    = miso_q;
  assign txMemAddr   = tx_addr_q;
  assign rcMemAddr   = rc_addr_q;
  assign rcMemData   = rc_data_q;
  assign rcMemWE     = rc_we_q;
  assign busy        = busy_q;
  assign frameDone   = done_q;
  assign rcWordCount = count_q;

endmodule

// File: tb/tb_spi_slave_mem_ifc.sv
// Directed bench for spi_slave_mem_ifc: mode 0 / 8-bit, mode 3 / 16-bit and a 2-bit-address
// instance, driven by a bit-banged SPI master with RAM models on both memory ports.
module tb_spi_slave_mem_ifc;

  localparam int HALF = 10;

  logic clk;
  logic rst;
  logic sclk0, sclk3, mosi;
  logic ss0, ss3, ssw;

  logic        miso0, we0, busy0, fd0;
  logic [11:0] ta0, ra0;
  logic [7:0]  td0, rd0;
  logic [12:0] cnt0;

  logic        miso3, we3, busy3, fd3;
  logic [11:0] ta3, ra3;
  logic [15:0] td3, rd3;
  logic [12:0] cnt3;

  logic        misow, wew, busyw, fdw;
  logic [1:0]  taw, raw;
  logic [7:0]  tdw, rdw;
  logic [2:0]  cntw;

  logic [7:0]  txm0 [16];
  logic [15:0] txm3 [16];
  logic [7:0]  txmw [4];

  int wa0[$], wd0[$], wa3[$], wd3[$], waw[$], wdw[$], tseq[$];
  int nfd0, nfd3, nfdw;
  int tests, fails;
  int sel;
  logic [63:0] cap;

  spi_slave_mem_ifc #(.WORD_W(8), .ADDR_W(12), .CPOL(1'b0), .CPHA(1'b0)) u0 (
    .SysClk(clk), .Reset(rst), .SPI_CLK(sclk0), .SPI_SS(ss0), .SPI_MOSI(mosi),
    .SPI_MISO(miso0), .txMemAddr(ta0), .txMemData(td0), .rcMemAddr(ra0),
    .rcMemData(rd0), .rcMemWE(we0), .busy(busy0), .frameDone(fd0), .rcWordCount(cnt0));

  spi_slave_mem_ifc #(.WORD_W(16), .ADDR_W(12), .CPOL(1'b1), .CPHA(1'b1)) u3 (
    .SysClk(clk), .Reset(rst), .SPI_CLK(sclk3), .SPI_SS(ss3), .SPI_MOSI(mosi),
    .SPI_MISO(miso3), .txMemAddr(ta3), .txMemData(td3), .rcMemAddr(ra3),
    .rcMemData(rd3), .rcMemWE(we3), .busy(busy3), .frameDone(fd3), .rcWordCount(cnt3));

  spi_slave_mem_ifc #(.WORD_W(8), .ADDR_W(2), .CPOL(1'b0), .CPHA(1'b0)) uw (
    .SysClk(clk), .Reset(rst), .SPI_CLK(sclk0), .SPI_SS(ssw), .SPI_MOSI(mosi),
    .SPI_MISO(misow), .txMemAddr(taw), .txMemData(tdw), .rcMemAddr(raw),
    .rcMemData(rdw), .rcMemWE(wew), .busy(busyw), .frameDone(fdw), .rcWordCount(cntw));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmit RAM models with one-cycle read latency
  always @(posedge clk) begin
    td0 <= txm0[ta0[3:0]];
    td3 <= txm3[ta3[3:0]];
    tdw <= txmw[taw];
  end

  // Receive-side and status monitors
  always @(negedge clk) begin
    if (we0) begin wa0.push_back(int'(ra0)); wd0.push_back(int'(rd0)); end
    if (we3) begin wa3.push_back(int'(ra3)); wd3.push_back(int'(rd3)); end
    if (wew) begin waw.push_back(int'(raw)); wdw.push_back(int'(rdw)); end
    if (fd0) nfd0++;
    if (fd3) nfd3++;
    if (fdw) nfdw++;
    if (busy0 && (tseq.size() == 0 || tseq[$] != int'(ta0))) tseq.push_back(int'(ta0));
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_sclk(input logic v);
    if (sel == 1) sclk3 = v;
    else          sclk0 = v;
  endtask

  task automatic drive_ss(input logic v);
    case (sel)
      0:       ss0 = v;
      1:       ss3 = v;
      default: ssw = v;
    endcase
  endtask

  function automatic logic get_miso();
    case (sel)
      0:       return miso0;
      1:       return miso3;
      default: return misow;
    endcase
  endfunction

  function automatic logic get_busy();
    case (sel)
      0:       return busy0;
      1:       return busy3;
      default: return busyw;
    endcase
  endfunction

  // Both modes used here sample on the rising pin edge; mode 0 ends on a falling edge
  task automatic xfer(input int nbits, input logic [63:0] data, output logic [63:0] c);
    c = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      drive_sclk(1'b0);
      mosi = data[i];
      wait_cyc(HALF);
      c = {c[62:0], get_miso()};
      drive_sclk(1'b1);
      wait_cyc(HALF);
    end
    if (sel != 1) begin
      drive_sclk(1'b0);
      wait_cyc(HALF);
    end
  endtask

  task automatic frame(input int nbits, input logic [63:0] data, output logic [63:0] c);
    drive_ss(1'b0);
    wait_cyc(20);
    check("busy_in_frame", 64'(get_busy()), 64'd1);
    xfer(nbits, data, c);
    wait_cyc(10);
    drive_ss(1'b1);
    wait_cyc(20);
  endtask

  task automatic clear_logs();
    wa0.delete(); wd0.delete(); wa3.delete(); wd3.delete(); waw.delete(); wdw.delete();
    tseq.delete();
    nfd0 = 0; nfd3 = 0; nfdw = 0;
  endtask

  initial begin
    int exp_a[6];
    int exp_d[6];
    exp_a = '{0, 1, 2, 3, 0, 1};
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    tests = 0; fails = 0; sel = 0;
    nfd0 = 0; nfd3 = 0; nfdw = 0;
    rst = 1'b1; sclk0 = 1'b0; sclk3 = 1'b1; mosi = 1'b0;
    ss0 = 1'b1; ss3 = 1'b1; ssw = 1'b1;
    for (int i = 0; i < 16; i++) begin txm0[i] = 8'h00; txm3[i] = 16'h0000; end
    for (int i = 0; i < 4; i++) txmw[i] = 8'h00;
    txm0[0] = 8'h81; txm0[1] = 8'h7E;
    txm3[0] = 16'h1234;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(10);

    // Reset state
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_miso", 64'(miso0), 64'd0);
    check("rst_addrs", {40'd0, ta0, ra0}, 64'd0);
    check("rst_rcdata_we_done", {54'd0, rd0, we0, fd0}, 64'd0);
    check("rst_count", 64'(cnt0), 64'd0);

    // Mode 0: receive 0xA5,0x3C while echoing tx RAM 0x81,0x7E
    sel = 0;
    clear_logs();
    frame(16, 64'hA53C, cap);
    check("m0_we_count", 64'(wa0.size()), 64'd2);
    check("m0_addr0", 64'(wa0[0]), 64'd0);
    check("m0_data0", 64'(wd0[0]), 64'hA5);
    check("m0_addr1", 64'(wa0[1]), 64'd1);
    check("m0_data1", 64'(wd0[1]), 64'h3C);
    check("m0_frame_done", 64'(nfd0), 64'd1);
    check("m0_word_count", 64'(cnt0), 64'd2);
    check("m0_busy_after", 64'(busy0), 64'd0);
    check("m0_rc_addr_final", 64'(ra0), 64'd2);
    check("m0_miso_echo", cap & 64'hFFFF, 64'h817E);
    check("m0_txaddr_seq0", 64'(tseq[0]), 64'd0);
    check("m0_txaddr_seq1", 64'(tseq[1]), 64'd1);
    check("m0_txaddr_seq2", 64'(tseq[2]), 64'd2);

    // Mode 3, 16-bit word
    sel = 1;
    clear_logs();
    frame(16, 64'hBEEF, cap);
    check("m3_we_count", 64'(wa3.size()), 64'd1);
    check("m3_addr0", 64'(wa3[0]), 64'd0);
    check("m3_data0", 64'(wd3[0]), 64'hBEEF);
    check("m3_miso", cap & 64'hFFFF, 64'h1234);
    check("m3_word_count", 64'(cnt3), 64'd1);
    check("m3_frame_done", 64'(nfd3), 64'd1);

    // Partial trailing word is discarded
    sel = 0;
    clear_logs();
    frame(13, 64'({8'hC3, 5'b10110}), cap);
    check("part_we_count", 64'(wa0.size()), 64'd1);
    check("part_addr0", 64'(wa0[0]), 64'd0);
    check("part_data0", 64'(wd0[0]), 64'hC3);
    check("part_word_count", 64'(cnt0), 64'd1);
    check("part_frame_done", 64'(nfd0), 64'd1);

    // Address wrap with ADDR_W=2; word counter saturates at 4
    sel = 2;
    clear_logs();
    frame(48, 64'h1122_3344_5566, cap);
    check("wrap_we_count", 64'(waw.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("wrap_addr%0d", i), 64'(waw[i]), 64'(exp_a[i]));
      check($sformatf("wrap_data%0d", i), 64'(wdw[i]), 64'(exp_d[i]));
    end
    check("wrap_word_count_sat", 64'(cntw), 64'd4);
    check("wrap_rc_addr_final", 64'(raw), 64'd2);

    // Reset mid-frame: in-flight frame ignored until SS cycles high then low
    sel = 0;
    clear_logs();
    drive_ss(1'b0);
    wait_cyc(20);
    xfer(4, 64'hF, cap);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(3);
    check("mid_rst_busy", 64'(busy0), 64'd0);
    check("mid_rst_addrs", {40'd0, ta0, ra0}, 64'd0);
    check("mid_rst_count", 64'(cnt0), 64'd0);
    check("mid_rst_miso", 64'(miso0), 64'd0);
    xfer(8, 64'hFF, cap);
    drive_ss(1'b1);
    wait_cyc(20);
    check("mid_rst_no_we", 64'(wa0.size()), 64'd0);
    check("mid_rst_no_done", 64'(nfd0), 64'd0);
    frame(8, 64'h5A, cap);
    check("post_rst_we_count", 64'(wa0.size()), 64'd1);
    check("post_rst_addr0", 64'(wa0[0]), 64'd0);
    check("post_rst_data0", 64'(wd0[0]), 64'h5A);
    check("post_rst_word_count", 64'(cnt0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
